// File: rtl/scan_pkg.sv
// Shared types and constants for the scanning select generator.
//   dir_state_e : bounce-direction FSM state (ST_UP / ST_DOWN)
//   MODE_*      : encodings of the i_mode input
//   SEL_MIN/MAX : end stops of the 3-bit select
//   cnt_width() : prescaler counter width for a given divide ratio
package scan_pkg;

  typedef enum logic [0:0] {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } dir_state_e;

  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  localparam logic [2:0] SEL_MIN = 3'd0;
  localparam logic [2:0] SEL_MAX = 3'd7;

  // A divide-by-one prescaler still needs a 1-bit counter to stay legal.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles 0..DIV-1 and flags the wrapping cycle.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset, count -> 0
//   i_en    : count enable; count holds while low
//   i_clr   : synchronous clear to 0, independent of i_en
//   o_step  : high in the enabled cycle whose edge wraps the count
module tick_gen
  import scan_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_step
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          at_last;

  assign at_last = (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      if (at_last) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // A clear wins over the step so the owner never sees a step it must discard.
  assign o_step = i_en & ~i_clr & at_last;

endmodule

// File: rtl/scan_sel_gen.sv
// Scanning select generator for a 3-to-8 decoder.
// Steps a 3-bit select every DIV enabled cycles, either wrapping (up or down)
// or bouncing between 0 and 7.
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_en       : step enable; prescaler and select hold while low
//   i_mode     : 0 = wrap, 1 = bounce
//   i_dir      : wrap direction, 0 = up, 1 = down (ignored when bouncing)
//   i_load     : synchronous load of i_load_val, also clears the prescaler
//   i_load_val : value to load
//   o_sel      : registered select
//   o_tick     : one-cycle pulse with each newly stepped o_sel
//   o_wrap     : one-cycle pulse on wrap-around or bounce reversal
module scan_sel_gen
  import scan_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_mode,
  input  logic       i_dir,
  input  logic       i_load,
  input  logic [2:0] i_load_val,
  output logic [2:0] o_sel,
  output logic       o_tick,
  output logic       o_wrap
);

  logic       step;
  dir_state_e state_q;
  logic [2:0] sel_q;
  logic       tick_q;
  logic       wrap_q;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_clr   (i_load),
    .o_step  (step)
  );

  // Select register, direction FSM and pulse outputs share one process so
  // the pulses line up with the select value they announce.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_UP;
      sel_q   <= SEL_MIN;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (i_load) begin
        sel_q <= i_load_val;
        // Loading an end stop leaves only one legal bounce direction.
        if (i_mode == MODE_BOUNCE) begin
          if (i_load_val == SEL_MAX) begin
            state_q <= ST_DOWN;
          end else if (i_load_val == SEL_MIN) begin
            state_q <= ST_UP;
          end
        end
      end else if (step) begin
        tick_q <= 1'b1;
        if (i_mode == MODE_WRAP) begin
          // Track the wrap direction so bounce mode picks up where wrap left off.
          if (i_dir) begin
            sel_q   <= sel_q - 3'd1;
            wrap_q  <= (sel_q == SEL_MIN);
            state_q <= ST_DOWN;
          end else begin
            sel_q   <= sel_q + 3'd1;
            wrap_q  <= (sel_q == SEL_MAX);
            state_q <= ST_UP;
          end
        end else begin
          case (state_q)
            ST_UP: begin
              if (sel_q == SEL_MAX) begin
                sel_q   <= SEL_MAX - 3'd1;
                state_q <= ST_DOWN;
                wrap_q  <= 1'b1;
              end else begin
                sel_q <= sel_q + 3'd1;
              end
            end
            ST_DOWN: begin
              if (sel_q == SEL_MIN) begin
                sel_q   <= SEL_MIN + 3'd1;
                state_q <= ST_UP;
                wrap_q  <= 1'b1;
              end else begin
                sel_q <= sel_q - 3'd1;
              end
            end
            default: state_q <= ST_UP;
          endcase
        end
      end
    end
  end

  assign o_sel  = sel_q;
  assign o_tick = tick_q;
  assign o_wrap = wrap_q;

endmodule

// File: doc/scan_sel_gen.md
SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

Interface
REQ-001 The module SHALL have parameter DIV, default 4, giving clock cycles per select step; legal range 1..2^20.
REQ-002 The module SHALL have port i_clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 The module SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port i_en, input, 1, step enable; when low, the prescaler and the select hold.
REQ-005 The module SHALL have port i_mode, input, 1, scan mode: 0 = wrap (circular), 1 = bounce (ping-pong).
REQ-006 The module SHALL have port i_dir, input, 1, wrap-mode direction: 0 = up, 1 = down; ignored in bounce mode.
REQ-007 The module SHALL have port i_load, input, 1, synchronous load strobe.
REQ-008 The module SHALL have port i_load_val, input, 3, the select value to load.
REQ-009 The module SHALL have port o_sel, output, 3, the registered select that drives the 3-to-8 decoder's i_sel.
REQ-010 The module SHALL have port o_tick, output, 1, a one-cycle pulse in the first cycle a stepped o_sel is visible.
REQ-011 The module SHALL have port o_wrap, output, 1, a one-cycle pulse on wrap-around or bounce reversal.

Function
REQ-012 The prescaler SHALL count 0..DIV-1 while i_en=1 and raise internal step when count==DIV-1 and i_en=1, returning the count to 0 on that edge; DIV=1 steps every enabled cycle.
REQ-013 In wrap mode with i_dir=0, each step SHALL set o_sel to o_sel+1 mod 8; 7->0 SHALL assert o_wrap.
REQ-014 In wrap mode with i_dir=1, each step SHALL set o_sel to o_sel-1 mod 8; 0->7 SHALL assert o_wrap.
REQ-015 Bounce mode SHALL use a two-state direction FSM, ST_UP and ST_DOWN.
REQ-016 In ST_UP, a step SHALL increment o_sel; at o_sel==7 it SHALL instead set o_sel=6, move to ST_DOWN and assert o_wrap.
REQ-017 In ST_DOWN, a step SHALL decrement o_sel; at o_sel==0 it SHALL instead set o_sel=1, move to ST_UP and assert o_wrap.
REQ-018 In wrap mode, the FSM state SHALL track i_dir on every step (0 -> ST_UP, 1 -> ST_DOWN), so that entering bounce mode continues in the last wrap direction.
REQ-019 o_sel, o_tick and o_wrap SHALL be registered; o_tick and o_wrap SHALL be high exactly in the cycle after the stepping edge, together with the new o_sel.
REQ-020 i_load=1 SHALL, on the next edge, set o_sel=i_load_val and clear the prescaler to 0; this happens regardless of i_en.
REQ-021 i_load SHALL take priority over a coincident step; that cycle SHALL produce no o_tick and no o_wrap.
REQ-022 After a load in bounce mode, the FSM state SHALL be unchanged, except that a load of 7 SHALL force ST_DOWN and a load of 0 SHALL force ST_UP.
REQ-023 A change of i_mode or i_dir SHALL take effect on the next step without disturbing the prescaler count.
REQ-024 Deasserting i_en SHALL freeze the prescaler count and o_sel; reasserting it SHALL resume from the frozen count.

Reset
REQ-025 i_rst_n=0 SHALL asynchronously set o_sel=0, o_tick=0, o_wrap=0, prescaler=0 and FSM=ST_UP.
REQ-026 Reset asserted mid-count or mid-bounce SHALL discard all progress; the first step after release SHALL occur DIV enabled cycles later.

Structure
REQ-027 Package scan_pkg SHALL hold the direction state type (ST_UP, ST_DOWN) and the mode constants MODE_WRAP=0 and MODE_BOUNCE=1.
REQ-028 The prescaler SHALL be a sub-module tick_gen (parameter DIV; ports i_clk, i_rst_n, i_en, i_clr, o_step), with counter width max(1, clog2(DIV)).
REQ-029 The select register, FSM and pulse outputs SHALL reside in scan_sel_gen.

Verification
REQ-030 Reset check: DIV=4, i_en=1, wrap up, from reset -> o_tick pulses every 4 cycles; o_sel = 1,2,...,7,0, with o_wrap only on the 7->0 step.
REQ-031 Wrap down: DIV=1, i_dir=1 -> o_sel = 7,6,...,0,7 on consecutive cycles, with o_wrap on 0->7.
REQ-032 Bounce: DIV=1, i_mode=1 from reset -> o_sel = 1..7,6..0,1; o_wrap exactly at the 7->6 and 0->1 steps.
REQ-033 Load priority: i_load=1 with i_load_val=5 on the step cycle -> o_sel=5 next cycle, o_tick=0, and the next step arrives DIV cycles later.
REQ-034 Enable freeze: drop i_en at prescaler count 2 (DIV=4) for 10 cycles -> o_sel is unchanged; the step arrives 1 enabled cycle after resume.
REQ-035 Async reset mid-bounce in ST_DOWN at o_sel=3 -> outputs are 0 immediately, with no clock edge required; the FSM restarts in ST_UP.
